hex_event_stream_writer: RTL

HEX_EVENT_STREAM_WRITER -- requirements
Module: hex_event_stream_writer

---
 rtl/hex_gpu_pkg.sv | 23 ++
 rtl/hex_batch_fifo.sv | 52 +++++
 rtl/hex_event_stream_writer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hex_gpu_pkg.sv
// Shared types for the hex event writer: packed event word, lane record width
// and serializer state encoding.
package hex_gpu_pkg;

  localparam int WORD_W = 64;
  localparam int LANE_W = 48;
  localparam int TAG_W  = 16;

  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] r;
    logic [7:0]         depth;
    logic [7:0]         material;
    logic [15:0]        frame_id;
  } hex_event_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } ser_state_t;

endpackage

// File: rtl/hex_batch_fifo.sv
// Power-of-two batch FIFO with show-ahead head and a flush that keeps a
// same-cycle push as the sole surviving entry.
module hex_batch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic             do_push;

  assign level   = wptr - rptr;
  assign full    = (level == (PW+1)'(DEPTH));
  assign empty   = (wptr == rptr);
  assign head    = mem[rptr[PW-1:0]];
  assign do_push = push && !full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= do_push ? (PW+1)'(1) : '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (pop && !empty)
        rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[flush ? '0 : wptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hex_event_stream_writer.sv
// Serializes masked lane batches into one 64-bit event word per cycle.
// Optional build macro HEX_EVENT_DEDUP_EN skips repeats of the last written (q,r).
module hex_event_stream_writer
  import hex_gpu_pkg::*;
#(
  parameter int LANES      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_DEPTH  = 256,
  parameter int WRAP_EN    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0]             lane_mask,
  input  logic signed [15:0]           q [LANES],
  input  logic signed [15:0]           r [LANES],
  input  logic [7:0]                   depth [LANES],
  input  logic [7:0]                   material [LANES],
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [WORD_W-1:0]            mem_wdata,
  output logic [31:0]                  write_count,
  output logic [31:0]                  drop_count,
  output logic [15:0]                  frame_id,
  output logic                         busy
);

  localparam int AW      = $clog2(MEM_DEPTH);
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FLW     = $clog2(FIFO_DEPTH);
  localparam int DATA_W  = LANES * LANE_W;
  localparam int ENTRY_W = DATA_W + LANES + TAG_W;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [LW-1:0] first_lane(input logic [LANES-1:0] m);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (m[i]) idx = LW'(i);
    return idx;
  endfunction

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [FLW:0]       fifo_level;

  ser_state_t         state;
  logic [DATA_W-1:0]  beat_lanes;
  logic [LANES-1:0]   rem_mask;
  logic [TAG_W-1:0]   beat_tag;

  logic [DATA_W-1:0]  src_lanes;
  logic [LANES-1:0]   src_mask;
  logic [TAG_W-1:0]   src_tag;
  logic [LANES-1:0]   rem_next;
  logic [LW-1:0]      sel;
  logic [LANE_W-1:0]  sel_lane;
  hex_event_t         ev;

  logic               has_evt;
  logic               dup;
  logic               do_write;
  logic               do_drop;
  logic               stop;
  logic [AW-1:0]      wr_ptr;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state == LOAD);
  assign busy      = !fifo_empty || (state != IDLE);

  // Input stage: a beat pushed alongside frame_start carries the new frame tag
  always_comb begin
    push_entry = '0;
    for (int i = 0; i < LANES; i++)
      push_entry[i*LANE_W +: LANE_W] = {q[i], r[i], depth[i], material[i]};
    push_entry[DATA_W +: LANES] = lane_mask;
    push_entry[ENTRY_W-1 -: TAG_W] = frame_start ? frame_id + 16'd1 : frame_id;
  end

  hex_batch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Select stage: LOAD emits straight from the FIFO head so beats chain gaplessly
  always_comb begin
    src_lanes = (state == LOAD) ? head_entry[DATA_W-1:0]         : beat_lanes;
    src_mask  = (state == LOAD) ? head_entry[DATA_W +: LANES]    : rem_mask;
    src_tag   = (state == LOAD) ? head_entry[ENTRY_W-1 -: TAG_W] : beat_tag;
    sel       = first_lane(src_mask);
    rem_next  = src_mask & ~(LANES'(1) << sel);
    sel_lane  = src_lanes[int'(sel)*LANE_W +: LANE_W];
    ev        = {sel_lane, src_tag};
    has_evt   = (state != IDLE) && (|src_mask);
  end

`ifdef HEX_EVENT_DEDUP_EN
  logic               last_vld;
  logic signed [15:0] last_q;
  logic signed [15:0] last_r;

  assign dup = has_evt && last_vld && (ev.q == last_q) && (ev.r == last_r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_vld <= 1'b0;
    else if (frame_start)
      last_vld <= 1'b0;
    else if (do_write)
      last_vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      last_q <= ev.q;
      last_r <= ev.r;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign do_write = has_evt && !dup && !stop;
  assign do_drop  = has_evt && !dup && stop;

  // Output stage: registered memory write port, counters and serializer FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rem_mask    <= '0;
      wr_ptr      <= '0;
      stop        <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      write_count <= '0;
      drop_count  <= '0;
      frame_id    <= '0;
    end else if (frame_start) begin
      state       <= IDLE;
      rem_mask    <= '0;
      wr_ptr      <= '0;
      stop        <= 1'b0;
      mem_we      <= 1'b0;
      write_count <= '0;
      drop_count  <= '0;
      frame_id    <= frame_id + 16'd1;
    end else begin
      mem_we <= do_write;
      if (do_write) begin
        mem_addr    <= wr_ptr;
        mem_wdata   <= ev;
        wr_ptr      <= wr_ptr + 1'b1;
        write_count <= sat_inc(write_count);
        if (WRAP_EN == 0 && wr_ptr == AW'(MEM_DEPTH - 1))
          stop <= 1'b1;
      end
      if (do_drop)
        drop_count <= sat_inc(drop_count);
      unique case (state)
        IDLE: begin
          if (!fifo_empty)
            state <= LOAD;
        end
        LOAD: begin
          rem_mask <= rem_next;
          if (|rem_next)
            state <= EMIT;
          else if (fifo_level > (FLW+1)'(1) || fifo_push)
            state <= LOAD;
          else
            state <= IDLE;
        end
        EMIT: begin
          rem_mask <= rem_next;
          if (!(|rem_next))
            state <= fifo_empty ? IDLE : LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      beat_lanes <= head_entry[DATA_W-1:0];
      beat_tag   <= head_entry[ENTRY_W-1 -: TAG_W];
    end
  end

endmodule
